freq_meas_sched: RTL

// Measurement scheduler for the gate-time frequency counter. It scans CH_NUM input channels

---
 rtl/freq_meas_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/freq_meas_sched.sv
`default_nettype none
// ============================================================================
// freq_meas_sched : round-robin gate-time frequency measurement scheduler
//                   with short/long gate auto-ranging and tagged results.
// Revision 1.0
// ============================================================================
module freq_meas_sched #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int CH_NUM      = 4,
  parameter int GATE_SHORT  = 1_000_000,
  parameter int GATE_LONG   = 100_000_000,
  parameter int AUTO_THRESH = 1000,
  parameter int SETTLE_CYC  = 10,
  localparam int CW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic [CH_NUM-1:0] sig_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CW-1:0]     res_ch,
  output logic [31:0]       res_freq,
  output logic              res_long,
  output logic              res_ovf,
  output logic              busy
);

  localparam logic [31:0] c_scale_short = 32'(CLK_HZ / GATE_SHORT);
  localparam logic [31:0] c_scale_long  = 32'(CLK_HZ / GATE_LONG);
  localparam logic [31:0] c_short_m1    = 32'(GATE_SHORT - 1);
  localparam logic [31:0] c_long_m1     = 32'(GATE_LONG - 1);
  localparam logic [31:0] c_settle_m1   = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] c_thresh      = 32'(AUTO_THRESH);
  localparam logic [CW-1:0] c_last_ch   = CW'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_GATE   = 3'd3,
    S_CALC   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_ch;
  logic          r_long;
  logic [31:0]   r_tmr;
  logic [31:0]   r_cnt;
  logic          r_ovf;
  logic [1:0]    r_sync;
  logic          r_prev;

  logic          w_sel;
  logic          w_edge;
  logic [CW:0]   w_pick;
  logic          w_found;
  logic          w_abort;
  logic          w_settle_end;
  logic          w_gate_end;
  logic          w_cnt_sat;
  logic [31:0]   w_cnt_nx;
  logic          w_ovf_nx;
  logic          w_go_long;
  logic [63:0]   w_prod;
  logic          w_prod_sat;

  // First enabled channel at or after the pointer, searching with wrap-around.
  function automatic logic [CW:0] f_pick(input logic [CW-1:0] ptr,
                                         input logic [CH_NUM-1:0] mask);
    logic [CW:0] w_res;
    int          idx;
    w_res = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % CH_NUM;
      if (mask[idx]) w_res = {1'b1, CW'(idx)};
    end
    return w_res;
  endfunction

  assign w_pick       = f_pick(r_ptr, ch_mask);
  assign w_found      = w_pick[CW];
  assign w_sel        = sig_in[r_ch];
  assign w_edge       = r_sync[1] & ~r_prev;
  assign w_abort      = !enable && (r_state == S_SELECT || r_state == S_SETTLE ||
                                    r_state == S_GATE   || r_state == S_CALC);
  assign w_settle_end = (r_tmr == c_settle_m1);
  assign w_gate_end   = (r_tmr == (r_long ? c_long_m1 : c_short_m1));
  assign w_cnt_sat    = &r_cnt;
  assign w_cnt_nx     = (w_edge && !w_cnt_sat) ? r_cnt + 32'd1 : r_cnt;
  assign w_ovf_nx     = r_ovf | (w_edge & w_cnt_sat);
  assign w_go_long    = !r_long && (w_cnt_nx < c_thresh);
  assign w_prod       = 64'(r_cnt) * 64'(r_long ? c_scale_long : c_scale_short);
  assign w_prod_sat   = |w_prod[63:32];

  assign res_valid = (r_state == S_RESULT);
  assign busy      = (r_state != S_IDLE);

  // Synchroniser keeps running in every state so SETTLE flushes the old channel.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], w_sel};
      r_prev <= r_sync[1];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable && (|ch_mask)) w_next = S_SELECT;
      S_SELECT: w_next = (!enable || !w_found) ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (!enable)          w_next = S_IDLE;
        else if (w_settle_end) w_next = S_GATE;
      end
      S_GATE: begin
        if (!enable)                      w_next = S_IDLE;
        else if (w_gate_end && !w_go_long) w_next = S_CALC;
      end
      S_CALC:   w_next = enable ? S_RESULT : S_IDLE;
      S_RESULT: if (res_ready) w_next = enable ? S_SELECT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_ch     <= '0;
      r_long   <= 1'b0;
      r_tmr    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      res_ch   <= '0;
      res_freq <= '0;
      res_long <= 1'b0;
      res_ovf  <= 1'b0;
    end else if (w_abort) begin
      r_tmr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmr <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end
        S_SELECT: begin
          if (w_found) r_ch <= w_pick[CW-1:0];
          r_long <= 1'b0;
          r_tmr  <= '0;
          r_cnt  <= '0;
          r_ovf  <= 1'b0;
        end
        S_SETTLE: r_tmr <= w_settle_end ? '0 : r_tmr + 32'd1;
        S_GATE: begin
          if (w_gate_end) begin
            r_tmr <= '0;
            if (w_go_long) begin
              // Low short-gate count: repeat immediately with the long gate.
              r_long <= 1'b1;
              r_cnt  <= '0;
              r_ovf  <= 1'b0;
            end else begin
              r_cnt <= w_cnt_nx;
              r_ovf <= w_ovf_nx;
            end
          end else begin
            r_tmr <= r_tmr + 32'd1;
            r_cnt <= w_cnt_nx;
            r_ovf <= w_ovf_nx;
          end
        end
        S_CALC: begin
          res_freq <= w_prod_sat ? 32'hFFFF_FFFF : w_prod[31:0];
          res_ch   <= r_ch;
          res_long <= r_long;
          res_ovf  <= r_ovf | w_prod_sat;
        end
        S_RESULT: begin
          if (res_ready) r_ptr <= (r_ch == c_last_ch) ? '0 : r_ch + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
